// File: rtl/sm3_pkg.sv
// rtl/sm3_pkg.sv - shared SM3 types, constants and helper functions
package sm3_pkg;

  typedef logic [31:0] word_t;

  // Working variables A..H; A lands in the most significant word when packed.
  typedef struct packed {
    word_t a;
    word_t b;
    word_t c;
    word_t d;
    word_t e;
    word_t f;
    word_t g;
    word_t h;
  } abc_t;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } fsm_e;

  localparam logic [255:0] SM3_IV =
    256'h7380166f4914b2b9172442d7da8a0600a96f30bc163138aae38dee4db0fb0e4e;
  localparam word_t SM3_T0 = 32'h79cc4519;
  localparam word_t SM3_T1 = 32'h7a879d8a;

  function automatic word_t rotl32(input word_t x, input logic [4:0] n);
    logic [63:0] t;
    t = {x, x} << n;
    return t[63:32];
  endfunction

  function automatic word_t p0(input word_t x);
    return x ^ rotl32(x, 5'd9) ^ rotl32(x, 5'd17);
  endfunction

  function automatic word_t p1(input word_t x);
    return x ^ rotl32(x, 5'd15) ^ rotl32(x, 5'd23);
  endfunction

  // Round constant already rotated by j mod 32, so rounds need no extra shift.
  function automatic word_t t_of(input logic [5:0] j);
    return (j < 6'd16) ? rotl32(SM3_T0, j[4:0]) : rotl32(SM3_T1, j[4:0]);
  endfunction

endpackage

// File: rtl/sm3_round.sv
// rtl/sm3_round.sv - one combinational SM3 compression round
module sm3_round
  import sm3_pkg::*;
(
  input  abc_t       i_s,
  input  word_t      i_wj,
  input  word_t      i_wj4,
  input  logic [5:0] i_j,
  output abc_t       o_s
);

  word_t a12, ss1, ss2, tt1, tt2, ff, gg;

  // Boolean functions switch from parity to majority/choose at round 16.
  always_comb begin
    a12 = rotl32(i_s.a, 5'd12);
    ss1 = rotl32(a12 + i_s.e + t_of(i_j), 5'd7);
    ss2 = ss1 ^ a12;
    if (i_j < 6'd16) begin
      ff = i_s.a ^ i_s.b ^ i_s.c;
      gg = i_s.e ^ i_s.f ^ i_s.g;
    end else begin
      ff = (i_s.a & i_s.b) | (i_s.a & i_s.c) | (i_s.b & i_s.c);
      gg = (i_s.e & i_s.f) | (~i_s.e & i_s.g);
    end
    tt1   = ff + i_s.d + ss2 + (i_wj ^ i_wj4);
    tt2   = gg + i_s.h + ss1 + i_wj;
    o_s.a = tt1;
    o_s.b = i_s.a;
    o_s.c = rotl32(i_s.b, 5'd9);
    o_s.d = i_s.c;
    o_s.e = p0(tt2);
    o_s.f = i_s.e;
    o_s.g = rotl32(i_s.f, 5'd19);
    o_s.h = i_s.g;
  end

endmodule

// File: rtl/sm3_core_x.sv
// rtl/sm3_core_x.sv - SM3 compression engine, UNROLL rounds per clock, internal chaining
module sm3_core_x
  import sm3_pkg::*;
#(
  parameter int           UNROLL = 1,
  parameter logic [255:0] IV     = SM3_IV
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic         i_first,
  input  logic [511:0] i_data,
  output logic [255:0] o_vout,
  output logic         o_done
);

  if (!(UNROLL == 1 || UNROLL == 2 || UNROLL == 4 || UNROLL == 8)) begin : g_bad_unroll
    $error("sm3_core_x: UNROLL must be 1, 2, 4 or 8");
  end

  localparam logic [5:0] STEP     = 6'(UNROLL);
  localparam logic [5:0] LAST_CNT = 6'(64 - UNROLL);

  fsm_e                   r_state, nxt_state;
  logic [5:0]             r_cnt;
  abc_t                   r_abc;
  logic [255:0]           r_v;
  logic [255:0]           r_digest;
  logic                   r_done;
  word_t [15:0]           r_w;
  word_t [15+UNROLL:0]    ext;
  abc_t                   round_out;
  logic [255:0]           load_v;
  logic                   accept;
  logic                   last;

  assign load_v = i_first ? IV : r_digest;
  assign o_vout = r_digest;
  assign o_done = r_done;

  // Round chain; r_w[0] always holds W for round r_cnt.
  for (genvar u = 0; u < UNROLL; u++) begin : g_round
    abc_t s_in, s_out;
    if (u == 0) begin : g_first
      assign s_in = r_abc;
    end else begin : g_next
      assign s_in = g_round[u-1].s_out;
    end
    sm3_round u_round (
      .i_s   (s_in),
      .i_wj  (r_w[u]),
      .i_wj4 (r_w[u+4]),
      .i_j   (r_cnt + 6'(u)),
      .o_s   (s_out)
    );
  end
  assign round_out = g_round[UNROLL-1].s_out;

  // Message expansion: extend the 16-word window by UNROLL new words, later words reuse earlier ones.
  always_comb begin
    ext       = '0;
    ext[15:0] = r_w;
    for (int k = 0; k < UNROLL; k++) begin
      ext[16+k] = p1(ext[k] ^ ext[k+7] ^ rotl32(ext[k+13], 5'd15))
                ^ rotl32(ext[k+3], 5'd7) ^ ext[k+10];
    end
  end

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= nxt_state;
  end

  // Next state and handshake decode.
  always_comb begin
    nxt_state = r_state;
    o_ready   = 1'b0;
    accept    = 1'b0;
    last      = 1'b0;
    case (r_state)
      S_IDLE: begin
        o_ready = 1'b1;
        if (i_valid) begin
          accept    = 1'b1;
          nxt_state = S_RUN;
        end
      end
      S_RUN: begin
        if (r_cnt == LAST_CNT) begin
          last      = 1'b1;
          nxt_state = S_IDLE;
        end
      end
      default: nxt_state = S_IDLE;
    endcase
  end

  // Datapath: load on accept, advance UNROLL rounds per RUN cycle, fold the digest on the last one.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt    <= '0;
      r_done   <= 1'b0;
      r_digest <= IV;
      r_abc    <= '0;
      r_v      <= '0;
      r_w      <= '0;
    end else begin
      r_done <= last;
      if (accept) begin
        r_abc <= load_v;
        r_v   <= load_v;
        r_cnt <= '0;
        for (int i = 0; i < 16; i++) r_w[i] <= i_data[511-32*i -: 32];
      end else if (r_state == S_RUN) begin
        r_abc <= round_out;
        r_w   <= ext[15+UNROLL:UNROLL];
        r_cnt <= last ? 6'd0 : r_cnt + STEP;
        if (last) r_digest <= r_v ^ round_out;
      end
    end
  end

endmodule

// File: tb/tb_sm3_core_x.sv
// tb/tb_sm3_core_x.sv - scoreboard bench for sm3_core_x at UNROLL 1, 2, 4 and 8
module tb_sm3_core_x;

  localparam logic [255:0] IV      = 256'h7380166f4914b2b9172442d7da8a0600a96f30bc163138aae38dee4db0fb0e4e;
  localparam logic [255:0] DIG_ABC = 256'h66c7f0f462eeedd9d1f2d46bdc10e4e24167c4875cf2f7a2297da02b8f4ba8e0;
  localparam logic [255:0] DIG_ABCD = 256'hdebe9ff92275b8a138604889c18e5a4d6fdb70e5387e5765293dcba39c0c5732;
  localparam logic [511:0] BLK_ABC = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [511:0] BLK_D1  = {16{32'h61626364}};
  localparam logic [511:0] BLK_D2  = {32'h80000000, 448'h0, 32'h00000200};

  typedef struct {
    int           k;
    logic [255:0] dig;
    int           cyc;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   valid;
  logic         first;
  logic [511:0] data;
  logic [3:0]   ready;
  logic [3:0]   done;
  logic [255:0] vout [4];

  int           cyc = 0;
  int           n_checks = 0;
  int           n_fail = 0;
  exp_t         q [$];
  logic [255:0] model_dig [4];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar gk = 0; gk < 4; gk++) begin : g_dut
    sm3_core_x #(.UNROLL(1 << gk)) u_dut (
      .i_clk   (clk),
      .i_rst   (rst),
      .i_valid (valid[gk]),
      .o_ready (ready[gk]),
      .i_first (first),
      .i_data  (data),
      .o_vout  (vout[gk]),
      .o_done  (done[gk])
    );
  end

  function automatic int nrounds(input int k);
    return 64 >> k;
  endfunction

  function automatic logic [31:0] rl(input logic [31:0] x, input int n);
    return (x << n) | (x >> (32 - n));
  endfunction

  function automatic logic [31:0] rp0(input logic [31:0] x);
    return x ^ rl(x, 9) ^ rl(x, 17);
  endfunction

  function automatic logic [31:0] rp1(input logic [31:0] x);
    return x ^ rl(x, 15) ^ rl(x, 23);
  endfunction

  // Straight textbook compression function: full 68-word schedule, 64 rounds.
  function automatic logic [255:0] ref_cf(input logic [255:0] v, input logic [511:0] b);
    logic [31:0] w [68];
    logic [31:0] a, bb, c, d, e, f, g, h, ss1, ss2, tt1, tt2, t, ff, gg;
    for (int i = 0; i < 16; i++) w[i] = b[511-32*i -: 32];
    for (int i = 16; i < 68; i++)
      w[i] = rp1(w[i-16] ^ w[i-9] ^ rl(w[i-3], 15)) ^ rl(w[i-13], 7) ^ w[i-6];
    {a, bb, c, d, e, f, g, h} = v;
    for (int j = 0; j < 64; j++) begin
      t   = (j < 16) ? 32'h79cc4519 : 32'h7a879d8a;
      ss1 = rl(rl(a, 12) + e + rl(t, j % 32), 7);
      ss2 = ss1 ^ rl(a, 12);
      ff  = (j < 16) ? (a ^ bb ^ c) : ((a & bb) | (a & c) | (bb & c));
      gg  = (j < 16) ? (e ^ f ^ g) : ((e & f) | (~e & g));
      tt1 = ff + d + ss2 + (w[j] ^ w[j+4]);
      tt2 = gg + h + ss1 + w[j];
      d = c; c = rl(bb, 9); bb = a; a = tt1;
      h = g; g = rl(f, 19); f = e; e = rp0(tt2);
    end
    return {a, bb, c, d, e, f, g, h} ^ v;
  endfunction

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  // Monitor: every o_done pops one expectation and checks instance, cycle and digest.
  always @(negedge clk) begin
    exp_t e;
    for (int k = 0; k < 4; k++) begin
      if (done[k] === 1'b1) begin
        if (q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_done: inst %0d got digest %h required no pulse", k, vout[k]);
        end else begin
          e = q.pop_front();
          chk("done_inst", 256'(k), 256'(e.k));
          chk("done_cycle", 256'(cyc), 256'(e.cyc));
          chk("digest", vout[k], e.dig);
        end
      end
    end
  end

  // Called at a negedge; returns at the negedge after the accept edge with valid dropped.
  task automatic send(input int k, input logic [511:0] d, input logic f,
                      input logic [255:0] exp, input bit push);
    int n;
    n = 0;
    valid[k] = 1'b1;
    data     = d;
    first    = f;
    while (ready[k] !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (ready[k] !== 1'b1) begin
      n_checks++;
      n_fail++;
      $display("FAIL accept_timeout: inst %0d got ready %b required 1", k, ready[k]);
    end else if (push) begin
      q.push_back('{k: k, dig: exp, cyc: cyc + nrounds(k) + 1});
      model_dig[k] = exp;
    end
    @(negedge clk);
    valid[k] = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain_timeout: got %0d pending required 0", q.size());
      q.delete();
    end
  endtask

  task automatic run_suite(input int k);
    int           n, rc;
    logic [511:0] rb;
    logic         rf;
    logic [255:0] re;
    n = nrounds(k);

    send(k, BLK_ABC, 1'b1, DIG_ABC, 1'b1);
    drain();

    send(k, BLK_D1, 1'b1, ref_cf(IV, BLK_D1), 1'b1);
    send(k, BLK_D2, 1'b0, DIG_ABCD, 1'b1);
    drain();

    send(k, BLK_ABC, 1'b1, DIG_ABC, 1'b1);
    drain();
    repeat (5) @(negedge clk);
    chk("vout_hold", vout[k], DIG_ABC);
    chk("ready_idle", 256'(ready[k]), 256'(1));

    send(k, BLK_ABC, 1'b1, DIG_ABC, 1'b1);
    for (int i = 1; i <= n; i++) begin
      valid[k] = 1'b1;
      for (int w = 0; w < 16; w++) data[511-32*w -: 32] = $urandom;
      first = 1'b1;
      chk("ready_in_run", 256'(ready[k]), 256'(0));
      @(negedge clk);
    end
    valid[k] = 1'b0;
    drain();
    chk("vout_after_noise", vout[k], DIG_ABC);

    rc = (n > 20) ? 20 : n / 2;
    send(k, BLK_ABC, 1'b1, 256'h0, 1'b0);
    repeat (rc - 1) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) model_dig[i] = IV;
    chk("vout_after_abort", vout[k], IV);
    chk("ready_after_abort", 256'(ready[k]), 256'(1));
    send(k, BLK_ABC, 1'b0, DIG_ABC, 1'b1);
    drain();

    for (int b = 0; b < 100; b++) begin
      for (int w = 0; w < 16; w++) rb[511-32*w -: 32] = $urandom;
      rf = ($urandom_range(0, 3) == 0);
      re = ref_cf(rf ? IV : model_dig[k], rb);
      send(k, rb, rf, re, 1'b1);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(n, n + 2)) @(negedge clk);
    end
    drain();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout at cycle %0d required completion", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst   = 1'b1;
    valid = 4'b0;
    first = 1'b0;
    data  = '0;
    for (int i = 0; i < 4; i++) model_dig[i] = IV;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      chk("reset_vout", vout[k], IV);
      chk("reset_ready", 256'(ready[k]), 256'(1));
      chk("reset_done", 256'(done[k]), 256'(0));
    end
    rst = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 4; k++) run_suite(k);
    drain();
    repeat (5) @(negedge clk);
    chk("queue_empty", 256'(q.size()), 256'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
